ps2_piano_input: RTL and testbench
==================================

# ps2_piano_input

Receives raw PS/2 keyboard traffic, deserialises 11-bit frames, and decodes make/break scan-code sequences into a held-key bitmap for two octaves. Its `pressed` output feeds the piano key renderer's `pressed` input directly, and it also feeds the tone generator's note selection. Bit i of `pressed` follows the renderer's semitone order: bit 0 = Do of octave 0, bit 1 = Do#, … bit 11 = Si, bit 12 = Do of octave 1, and so on.

## Interface
- `octaves`, 2, octave count; the key map is defined for exactly 2, so `pressed` is 24 bits.
- `timeoutCycles`, 50000, idle clocks allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- `clk` in 1 system clock; one clock domain.
- `rst` in 1 synchronous, active-high reset.
- `ps2Clk` in 1 raw PS/2 clock, asynchronous.
- `ps2Data` in 1 raw PS/2 data, asynchronous.
- `pressed` out 24 held-key bitmap; 1 = key held.
- `keyEvent` out 1 one-cycle pulse when a `pressed` bit changes.
- `keyIndex` out 5 index of the changed key; valid while `keyEvent` is high.
- `keyDown` out 1 1 = press, 0 = release; valid while `keyEvent` is high.
- `frameErr` out 1 one-cycle pulse on a parity, start-bit or stop-bit error, or on a timeout.

## Operation
- **Input sync:** `ps2Clk` and `ps2Data` each pass through a 2-FF synchroniser. A falling edge is detected when the previous synced clock = 1 and the current = 0.
- **Receiver:** a 4-bit bit counter, an 11-bit shift register, and a timeout counter.
  - One bit is sampled per falling edge, LSB first: start, d0..d7, odd parity, stop.
  - After the 11th bit the frame is checked: start = 0, stop = 1, and d0..d7 plus parity has odd weight.
  - If the frame is good, `codeValid` pulses internally with the 8-bit code. If not, `frameErr` pulses and the frame is dropped.
  - The timeout counter clears on every falling edge and counts only while the bit counter ≠ 0. When it reaches `timeoutCycles`, the bit counter clears and `frameErr` pulses.
- **Decoder FSM** (states IDLE, BRK, EXT, EXTBRK; it advances only on `codeValid`):
  - IDLE: code E0 → EXT; F0 → BRK; a mapped code → make; any other code → IDLE.
  - BRK: a mapped code → break; any code → IDLE.
  - EXT: F0 → EXTBRK; any other code → IDLE, ignored.
  - EXTBRK: any code → IDLE, ignored. Extended keys never affect `pressed`.
- **Key map, octave 0** (indices 0-11): 1A, 1B, 22, 23, 21, 2A, 34, 32, 33, 31, 3B, 3A (Z S X D C V G B H N J M).
- **Key map, octave 1** (indices 12-23): 15, 1E, 1D, 26, 24, 2D, 2E, 2C, 36, 35, 3D, 3C (Q 2 W 3 E R 5 T 6 Y 7 U).
- **Make:** if the bit is clear, set it and pulse `keyEvent` with `keyDown` = 1. If it is already set (typematic repeat), change nothing and emit no event.
- **Break:** if the bit is set, clear it and pulse `keyEvent` with `keyDown` = 0. If it is already clear, change nothing and emit no event.
- A prefix state persists indefinitely until the next valid code; a `frameErr` does not change the FSM state.
- Multiple keys may be held; bits are independent.

## Timing
- **Reset values:** `pressed` = 0, `keyEvent` = 0, `keyIndex` = 0, `keyDown` = 0, `frameErr` = 0. FSM = IDLE, bit counter = 0, timeout = 0, synchroniser FFs = 1 (line idle).
- **Edge latency:** the falling-edge detect is registered 3 clocks after the raw `ps2Clk` edge.
- **Code latency:** `codeValid` is asserted in the cycle after the 11th detected edge.
- **Key latency:** `pressed`, `keyEvent`, `keyIndex` and `keyDown` update on the same clock edge, 1 cycle after `codeValid`.
- **Error latency:** `frameErr` occurs in the same cycle in which `codeValid` would have occurred.
- **Reset mid-frame:** `rst` asserted during a frame discards it immediately. The next frame is received normally only if it begins after `rst` is released; the partial frame's remaining edges may cause one timeout or error.
- `keyIndex` and `keyDown` hold their last values when `keyEvent` = 0.
- **PS/2 limits:** the PS/2 clock is 10-16.7 kHz. The block needs `clk` ≥ 8× the PS/2 clock; the design targets 50 MHz.

## Test plan
- **Reset:** hold `rst` 5 cycles → all outputs 0; idle lines produce no events.
- **Octave-0 Do press and release:** frame 1A, then F0 1A → `keyEvent`/`keyDown` = 1/`keyIndex` = 0 with `pressed` = 24'h000001, then `keyEvent`/`keyDown` = 0/`keyIndex` = 0 with `pressed` = 0.
- **Chord plus typematic:** 15, 3C, 15, 15 → `pressed` = 24'h801000 (bits 12 and 23); exactly 2 events.
- **Extended and unmapped codes:** E0 1A, E0 F0 1A, 1C, F0 1C → `pressed` stays 0, no events.
- **Parity error:** frame 1A with even parity → `frameErr` pulse, no event. A following good 1A → bit 0 set.
- **Timeout:** 5 bits of a frame, then idle ≥ `timeoutCycles` → `frameErr` pulse. A following complete 22 frame → `pressed` = 24'h000004.

Source files
------------

// File: rtl/ps2_piano_input_if.sv
// -----------------------------------------------------------------------------
// ps2_piano_input_if
//
// Purpose: bundles the PS/2 line inputs and the decoded key outputs of
//          ps2_piano_input so the piano front end can be wired as one port.
//
// Signals:
//   ps2Clk    raw PS/2 clock (asynchronous to clk)
//   ps2Data   raw PS/2 data  (asynchronous to clk)
//   pressed   24-bit held-key bitmap, bit i = semitone i (Do of octave 0 = 0)
//   keyEvent  one-cycle pulse when a pressed bit changes
//   keyIndex  index of the changed key, valid with keyEvent
//   keyDown   1 = press, 0 = release, valid with keyEvent
//   frameErr  one-cycle pulse on parity/start/stop error or frame timeout
//
// Modports:
//   slave   the receiver/decoder (consumes the PS/2 lines, drives key outputs)
//   master  the keyboard side / consumer (drives PS/2 lines, reads outputs)
// -----------------------------------------------------------------------------
interface ps2_piano_input_if;
   logic        ps2Clk;
   logic        ps2Data;
   logic [23:0] pressed;
   logic        keyEvent;
   logic [4:0]  keyIndex;
   logic        keyDown;
   logic        frameErr;

   modport slave (
      input  ps2Clk,
      input  ps2Data,
      output pressed,
      output keyEvent,
      output keyIndex,
      output keyDown,
      output frameErr
   );

   modport master (
      output ps2Clk,
      output ps2Data,
      input  pressed,
      input  keyEvent,
      input  keyIndex,
      input  keyDown,
      input  frameErr
   );
endinterface

// File: rtl/ps2_piano_input.sv
// -----------------------------------------------------------------------------
// ps2_piano_input
//
// Purpose: receives raw PS/2 keyboard traffic, deserialises 11-bit frames
//          (start, d0..d7, odd parity, stop) and turns make/break scan-code
//          sequences into a held-key bitmap covering two octaves.
//
// Parameters:
//   octaves        octave count; the key map covers exactly 2 (24 keys)
//   timeoutCycles  idle clk cycles tolerated between PS/2 falling edges
//                  inside a frame before the partial frame is abandoned
//
// Ports:
//   clk   system clock (single domain, >= 8x the PS/2 clock)
//   rst   synchronous active-high reset
//   bus   ps2_piano_input_if.slave: ps2Clk/ps2Data in; pressed, keyEvent,
//         keyIndex, keyDown, frameErr out
//
// Latency: falling edge detected 3 clk after the raw edge; codeValid the
//          cycle after the 11th edge; key outputs one cycle after codeValid.
//          frameErr lands in the cycle codeValid would have.
// -----------------------------------------------------------------------------
module ps2_piano_input #(
   parameter int octaves       = 2,
   parameter int timeoutCycles = 50000
) (
   input  logic                clk,
   input  logic                rst,
   ps2_piano_input_if.slave    bus
);

   localparam int NUM_KEYS = 12 * octaves;
   localparam int TO_W     = $clog2(timeoutCycles + 1);

   // Scan codes in semitone order: Z S X D C V G B H N J M, Q 2 W 3 E R 5 T 6 Y 7 U
   localparam logic [7:0] KEY_MAP [24] = '{
      8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
      8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
      8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D,
      8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
   };

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BRK    = 2'd1,
      ST_EXT    = 2'd2,
      ST_EXTBRK = 2'd3
   } dec_state_t;

   // ---------------------------------------------------------------------
   // Input synchronisers and falling-edge detect
   // ---------------------------------------------------------------------
   logic ps2_clk_s1_q,  ps2_clk_s2_q,  ps2_clk_prev_q;
   logic ps2_data_s1_q, ps2_data_s2_q;
   logic fall_q,        fall_d;
   logic data_samp_q;

   assign fall_d = ps2_clk_prev_q & ~ps2_clk_s2_q;

   // All line FFs reset to 1 so a reset never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps2_clk_s1_q   <= 1'b1;
         ps2_clk_s2_q   <= 1'b1;
         ps2_clk_prev_q <= 1'b1;
         ps2_data_s1_q  <= 1'b1;
         ps2_data_s2_q  <= 1'b1;
         fall_q         <= 1'b0;
         data_samp_q    <= 1'b1;
      end else begin
         ps2_clk_s1_q   <= bus.ps2Clk;
         ps2_clk_s2_q   <= ps2_clk_s1_q;
         ps2_clk_prev_q <= ps2_clk_s2_q;
         ps2_data_s1_q  <= bus.ps2Data;
         ps2_data_s2_q  <= ps2_data_s1_q;
         fall_q         <= fall_d;
         // Data captured alongside the edge flag so both stay aligned.
         data_samp_q    <= ps2_data_s2_q;
      end
   end

   // ---------------------------------------------------------------------
   // Frame receiver
   // ---------------------------------------------------------------------
   logic [3:0]      bit_cnt_q,    bit_cnt_d;
   logic [9:0]      shift_q,      shift_d;     // the 10 bits seen before the current one
   logic [TO_W-1:0] timeout_q,    timeout_d;
   logic            code_valid_q, code_valid_d;
   logic [7:0]      code_q,       code_d;
   logic            frame_err_q,  frame_err_d;
   logic [10:0]     frame;

   // Current bit appended at the MSB: after the 11th bit, frame[0] is start.
   assign frame = {data_samp_q, shift_q};

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      timeout_d    = timeout_q;
      code_valid_d = 1'b0;
      code_d       = code_q;
      frame_err_d  = 1'b0;

      if (fall_q) begin
         timeout_d = '0;
         shift_d   = frame[10:1];
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
               code_valid_d = 1'b1;
               code_d       = frame[8:1];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         // Only a partially received frame can time out.
         if (timeout_q == TO_W'(timeoutCycles)) begin
            bit_cnt_d   = 4'd0;
            timeout_d   = '0;
            frame_err_d = 1'b1;
         end else begin
            timeout_d = timeout_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         timeout_q    <= '0;
         code_valid_q <= 1'b0;
         code_q       <= 8'd0;
         frame_err_q  <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         timeout_q    <= timeout_d;
         code_valid_q <= code_valid_d;
         code_q       <= code_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Scan code to key index lookup
   // ---------------------------------------------------------------------
   logic [NUM_KEYS-1:0] key_hit;
   logic                key_found;
   logic [4:0]          key_idx;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_match
      assign key_hit[gi] = (code_q == KEY_MAP[gi]);
   end

   // Codes in the map are unique, so at most one hit bit is ever set.
   always_comb begin
      key_found = |key_hit;
      key_idx   = 5'd0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (key_hit[i]) key_idx = 5'(i);
      end
   end

   // ---------------------------------------------------------------------
   // Make/break decoder
   // ---------------------------------------------------------------------
   dec_state_t          state_q,     state_d;
   logic [NUM_KEYS-1:0] pressed_q,   pressed_d;
   logic                key_event_q, key_event_d;
   logic [4:0]          key_index_q, key_index_d;
   logic                key_down_q,  key_down_d;

   always_comb begin
      state_d     = state_q;
      pressed_d   = pressed_q;
      key_event_d = 1'b0;
      key_index_d = key_index_q;
      key_down_d  = key_down_q;

      if (code_valid_q) begin
         case (state_q)
            ST_IDLE: begin
               if (code_q == CODE_EXT) begin
                  state_d = ST_EXT;
               end else if (code_q == CODE_BRK) begin
                  state_d = ST_BRK;
               end else if (key_found && !pressed_q[key_idx]) begin
                  // Typematic repeats of a held key fall through silently.
                  pressed_d[key_idx] = 1'b1;
                  key_event_d        = 1'b1;
                  key_index_d        = key_idx;
                  key_down_d         = 1'b1;
               end
            end
            ST_BRK: begin
               state_d = ST_IDLE;
               if (key_found && pressed_q[key_idx]) begin
                  pressed_d[key_idx] = 1'b0;
                  key_event_d        = 1'b1;
                  key_index_d        = key_idx;
                  key_down_d         = 1'b0;
               end
            end
            ST_EXT: begin
               // Extended keys are swallowed; only track the break prefix.
               state_d = (code_q == CODE_BRK) ? ST_EXTBRK : ST_IDLE;
            end
            ST_EXTBRK: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pressed_q   <= '0;
         key_event_q <= 1'b0;
         key_index_q <= 5'd0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pressed_q   <= pressed_d;
         key_event_q <= key_event_d;
         key_index_q <= key_index_d;
         key_down_q  <= key_down_d;
      end
   end

   assign bus.pressed  = pressed_q;
   assign bus.keyEvent = key_event_q;
   assign bus.keyIndex = key_index_q;
   assign bus.keyDown  = key_down_q;
   assign bus.frameErr = frame_err_q;

endmodule

// File: tb/tb_ps2_piano_input.sv
// -----------------------------------------------------------------------------
// tb_ps2_piano_input
//
// Directed bench for ps2_piano_input. Expected key events are queued as
// frames are sent and a monitor pops/compares them as keyEvent pulses arrive.
// A shortened timeout and a fast PS/2 clock keep the run short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_piano_input;

   localparam int TIMEOUT = 200;   // clk cycles
   localparam int HALF    = 20;    // PS/2 half period in clk cycles

   typedef struct packed {
      logic [4:0]  idx;
      logic        down;
      logic [23:0] pr;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   ps2_piano_input_if bus ();

   ps2_piano_input #(
      .octaves       (2),
      .timeoutCycles (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ev_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  events_seen = 0;
   int  errs_seen   = 0;
   int  errs_exp    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] idx, input logic down, input logic [23:0] pr);
      ev_t e;
      e.idx  = idx;
      e.down = down;
      e.pr   = pr;
      exp_q.push_back(e);
   endtask

   // Sends the first nbits of a frame; odd parity unless bad_par.
   task automatic send_frame(input logic [7:0] code, input int nbits = 11,
                             input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2Data = f[i];
         repeat (HALF) @(negedge clk);
         bus.ps2Clk = 1'b0;
         repeat (HALF) @(negedge clk);
         bus.ps2Clk = 1'b1;
      end
      bus.ps2Data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.keyEvent) begin
            ev_t e;
            events_seen++;
            chk("event_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("keyIndex", 32'(bus.keyIndex), 32'(e.idx));
               chk("keyDown",  32'(bus.keyDown),  32'(e.down));
               chk("ev_pressed", 32'(bus.pressed), 32'(e.pr));
            end
         end
         if (bus.frameErr) errs_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev_base;
      bus.ps2Clk  = 1'b1;
      bus.ps2Data = 1'b1;

      // Reset
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_pressed",  32'(bus.pressed),  32'd0);
      chk("rst_keyEvent", 32'(bus.keyEvent), 32'd0);
      chk("rst_keyIndex", 32'(bus.keyIndex), 32'd0);
      chk("rst_keyDown",  32'(bus.keyDown),  32'd0);
      chk("rst_frameErr", 32'(bus.frameErr), 32'd0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("idle_events", 32'(events_seen), 32'd0);

      // Octave-0 Do press and release
      push(5'd0, 1'b1, 24'h000001);
      send_frame(8'h1A);
      chk("do_press", 32'(bus.pressed), 32'h000001);
      send_frame(8'hF0);
      push(5'd0, 1'b0, 24'h000000);
      send_frame(8'h1A);
      chk("do_release", 32'(bus.pressed), 32'h000000);

      // Chord plus typematic repeats
      ev_base = events_seen;
      push(5'd12, 1'b1, 24'h001000);
      send_frame(8'h15);
      push(5'd23, 1'b1, 24'h801000);
      send_frame(8'h3C);
      send_frame(8'h15);
      send_frame(8'h15);
      chk("chord_pressed", 32'(bus.pressed), 32'h801000);
      chk("chord_events", 32'(events_seen - ev_base), 32'd2);
      send_frame(8'hF0);
      push(5'd12, 1'b0, 24'h800000);
      send_frame(8'h15);
      send_frame(8'hF0);
      push(5'd23, 1'b0, 24'h000000);
      send_frame(8'h3C);
      chk("chord_release", 32'(bus.pressed), 32'h000000);

      // Extended, unmapped, and break of an unheld key
      ev_base = events_seen;
      send_frame(8'hE0); send_frame(8'h1A);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h1A);
      send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'hF0); send_frame(8'h1B);
      chk("ext_pressed", 32'(bus.pressed), 32'h000000);
      chk("ext_events", 32'(events_seen - ev_base), 32'd0);

      // Parity error, then a good frame
      send_frame(8'h1A, 11, 1'b1, 1'b0);
      errs_exp++;
      chk("parity_err", 32'(errs_seen), 32'(errs_exp));
      chk("parity_pressed", 32'(bus.pressed), 32'h000000);
      push(5'd0, 1'b1, 24'h000001);
      send_frame(8'h1A);
      chk("after_parity", 32'(bus.pressed), 32'h000001);

      // Stop-bit error
      send_frame(8'h1B, 11, 1'b0, 1'b1);
      errs_exp++;
      chk("stop_err", 32'(errs_seen), 32'(errs_exp));
      chk("stop_pressed", 32'(bus.pressed), 32'h000001);
      send_frame(8'hF0);
      push(5'd0, 1'b0, 24'h000000);
      send_frame(8'h1A);

      // Timeout on a 5-bit partial frame, then a good 22
      send_frame(8'h22, 5);
      repeat (TIMEOUT + 100) @(negedge clk);
      errs_exp++;
      chk("timeout_err", 32'(errs_seen), 32'(errs_exp));
      push(5'd2, 1'b1, 24'h000004);
      send_frame(8'h22);
      chk("after_timeout", 32'(bus.pressed), 32'h000004);

      // Reset during a partial frame discards it without a later timeout
      send_frame(8'h1C, 4);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_pressed", 32'(bus.pressed), 32'h000000);
      rst = 1'b0;
      repeat (TIMEOUT + 100) @(negedge clk);
      chk("midrst_no_err", 32'(errs_seen), 32'(errs_exp));
      push(5'd1, 1'b1, 24'h000002);
      send_frame(8'h1B);
      chk("midrst_next", 32'(bus.pressed), 32'h000002);

      repeat (20) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("final_errs", 32'(errs_seen), 32'(errs_exp));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
